id_decode_pipe: RTL

- Registered instruction-decode (ID) stage for the RV32I core.
- Takes a fetched instruction and its PC from IF over a valid/ready handshake. Classifies the instruction, selects the immediate format and produces the sign-extended immediate.
- Presents the result to EX through a one-cycle pipeline register backed by a one-entry skid buffer, so that o_ready is a registered signal.
- Generalises the earlier combinational imm_sel decoder:
  - parametrised datapath width;
  - full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU), LUI, JALR;
  - illegal-instruction flagging;
  - stall and flush handling.

---
 rtl/id_decode_pipe.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_decode_pipe.sv
// ---------------------------------------------------------------------------
// id_decode_pipe
//
// Registered instruction-decode stage for the RV32I core. An instruction and
// its PC arrive from IF over a valid/ready handshake. They are decoded
// combinationally: class flags, immediate format, the sign-extended immediate
// and the register indices. The result is held for EX in a one-entry output
// register. A one-entry skid buffer sits behind it so that o_ready can come
// straight from a flop.
//
// Optional feature macro: ID_PERF_CNT_EN
//   When defined, the block adds two 32-bit performance counters:
//   o_cnt_issued counts output transfers, and o_cnt_illegal counts output
//   transfers that carry an illegal instruction.
//
// Parameters:
//   XLEN      width of the PC and immediate datapath (32 or 64)
//   RESET_PC  value shown on o_pc while the stage is empty after reset
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               synchronous kill of everything buffered
//   i_valid/o_ready       upstream handshake (o_ready = ~skid_valid)
//   i_instr, i_pc         instruction word and its PC
//   o_valid/i_ready       downstream handshake
//   o_pc, o_imm           PC and sign-extended immediate
//   o_imm_sel             0=I 1=S 2=B 3=U 4=J 5=shamt 7=none
//   o_rd, o_rs1, o_rs2    register indices, zero when unused by the format
//   o_is_load/store/branch/jump, o_illegal   instruction class
//   o_cnt_issued, o_cnt_illegal              perf counters (feature only)
// ---------------------------------------------------------------------------
module id_decode_pipe #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_imm_sel,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic            o_is_load,
    output logic            o_is_store,
    output logic            o_is_branch,
    output logic            o_is_jump,
    output logic            o_illegal
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]     o_cnt_issued,
    output logic [31:0]     o_cnt_illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] SEL_I     = 3'd0;
    localparam logic [2:0] SEL_S     = 3'd1;
    localparam logic [2:0] SEL_B     = 3'd2;
    localparam logic [2:0] SEL_U     = 3'd3;
    localparam logic [2:0] SEL_J     = 3'd4;
    localparam logic [2:0] SEL_SHAMT = 3'd5;
    localparam logic [2:0] SEL_NONE  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded instruction as held in the output register or skid entry.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      sel;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } entry_t;

    function automatic entry_t empty_entry();
        entry_t e;
        e     = '0;
        e.pc  = RESET_PC;
        e.sel = SEL_NONE;
        return e;
    endfunction

    entry_t dec;
    entry_t out_q;
    entry_t sk_q;
    logic   out_valid;
    logic   sk_valid;
    logic   accept;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] imm32;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // Combinational decode of the offered instruction. The format is chosen
    // first. An illegal encoding then wipes the format, flags and register
    // fields, so EX only sees the illegal bit. The 32-bit immediate is
    // widened with a signed cast. Shift amounts have bit 31 clear, so the
    // cast leaves them zero-extended.
    always_comb begin
        dec     = '0;
        dec.pc  = i_pc;
        dec.sel = SEL_NONE;
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm32   = '0;

        case (opcode)
            OPC_OP: begin
                legal   = (funct7 == F7_BASE) ||
                          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                if (funct3 == 3'b001) begin
                    legal   = (funct7 == F7_BASE);
                    dec.sel = SEL_SHAMT;
                end else if (funct3 == 3'b101) begin
                    legal   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    dec.sel = SEL_SHAMT;
                end else begin
                    legal   = 1'b1;
                    dec.sel = SEL_I;
                end
            end
            OPC_LOAD: begin
                legal       = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                dec.sel     = SEL_I;
                dec.is_load = 1'b1;
                use_rd      = 1'b1;
                use_rs1     = 1'b1;
            end
            OPC_STORE: begin
                legal        = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                dec.sel      = SEL_S;
                dec.is_store = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OPC_BRANCH: begin
                legal         = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.sel       = SEL_B;
                dec.is_branch = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_JAL: begin
                legal       = 1'b1;
                dec.sel     = SEL_J;
                dec.is_jump = 1'b1;
                use_rd      = 1'b1;
            end
            OPC_JALR: begin
                legal       = (funct3 == 3'b000);
                dec.sel     = SEL_I;
                dec.is_jump = 1'b1;
                use_rd      = 1'b1;
                use_rs1     = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                legal   = 1'b1;
                dec.sel = SEL_U;
                use_rd  = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (!legal) begin
            dec.sel       = SEL_NONE;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
            dec.illegal   = 1'b1;
            use_rd        = 1'b0;
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
        end

        case (dec.sel)
            SEL_I:     imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            SEL_S:     imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            SEL_B:     imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            SEL_U:     imm32 = {i_instr[31:12], 12'b0};
            SEL_J:     imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            SEL_SHAMT: imm32 = {27'b0, i_instr[24:20]};
            default:   imm32 = '0;
        endcase

        dec.imm = XLEN'(signed'(imm32));
        dec.rd  = use_rd  ? i_instr[11:7]  : 5'd0;
        dec.rs1 = use_rs1 ? i_instr[19:15] : 5'd0;
        dec.rs2 = use_rs2 ? i_instr[24:20] : 5'd0;
    end

    assign accept = i_valid & ~sk_valid;

    // Output register plus skid entry. While the skid entry is full, o_ready
    // is low, so a new instruction cannot arrive. The only event left is EX
    // draining the output register, which promotes the skid entry. Otherwise
    // a new instruction goes to the output register if it is free or being
    // consumed this cycle, and into the skid entry if not. A flush beats all
    // of these: both valids drop, and the data fields are left as they were.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q     <= empty_entry();
            sk_q      <= empty_entry();
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
        end else if (i_flush) begin
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
        end else if (sk_valid) begin
            if (i_ready) begin
                out_q    <= sk_q;
                sk_valid <= 1'b0;
            end
        end else if (accept && (!out_valid || i_ready)) begin
            out_q     <= dec;
            out_valid <= 1'b1;
        end else if (accept) begin
            sk_q     <= dec;
            sk_valid <= 1'b1;
        end else if (i_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign o_ready     = ~sk_valid;
    assign o_valid     = out_valid;
    assign o_pc        = out_q.pc;
    assign o_imm       = out_q.imm;
    assign o_imm_sel   = out_q.sel;
    assign o_rd        = out_q.rd;
    assign o_rs1       = out_q.rs1;
    assign o_rs2       = out_q.rs2;
    assign o_is_load   = out_q.is_load;
    assign o_is_store  = out_q.is_store;
    assign o_is_branch = out_q.is_branch;
    assign o_is_jump   = out_q.is_jump;
    assign o_illegal   = out_q.illegal;

`ifdef ID_PERF_CNT_EN
    logic xfer;

    // A transfer in a flush cycle is not counted. The flushed entry never
    // reaches EX as a real instruction.
    assign xfer = out_valid & i_ready & ~i_flush;

    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt_issued  <= '0;
            o_cnt_illegal <= '0;
        end else if (xfer) begin
            o_cnt_issued <= o_cnt_issued + 32'd1;
            if (out_q.illegal) begin
                o_cnt_illegal <= o_cnt_illegal + 32'd1;
            end
        end
    end
`endif

endmodule
